// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment display driver.
package seg_pkg;

  // Active-low segment patterns, bit order g..a (bit 0 = a).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ALL   = 7'h00;

  // Glyphs 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Clocks per blink half-period; 0 flags an unusable configuration.
  function automatic int blink_div(input int clk_hz, input int blink_hz);
    if (blink_hz <= 0) return 0;
    return clk_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for one hex digit.
  always_comb begin
    seg_o = SEG_GLYPH[nibble_i];
  end

endmodule

// File: rtl/hex_display_driver_n.sv
// N-digit hex display driver: capture register, blink prescaler,
// leading-zero blanking, lamp test and registered active-low outputs.
module hex_display_driver_n
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic                      load,
  input  logic                      live,
  input  logic                      lzb_en,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lamp_test,
  output logic [7*NUM_DIGITS-1:0]   hex_out,
  output logic                      blink_phase
);

  localparam int BLINK_DIV = blink_div(CLK_HZ, BLINK_HZ);
  localparam int CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  if (BLINK_DIV < 1) begin : g_div_check
    $error("hex_display_driver_n: BLINK_DIV must be at least 1");
  end

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [CNT_W-1:0]        blink_cnt_q;
  logic                    blink_phase_q;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [7*NUM_DIGITS-1:0] glyph;
  logic                    zero_run;

  // Capture value_in on load, or every cycle while live.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      value_q <= '0;
    end else if (live || load) begin
      value_q <= value_in;
    end
  end

  // Free-running blink prescaler; phase flips on each counter wrap.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    hex_to_seg u_dec (
      .nibble_i (value_q[4*k +: 4]),
      .seg_o    (glyph[7*k +: 7])
    );
  end

  // Per-digit priority: lamp test, leading-zero blank, blink, glyph.
  // zero_run walks from the top digit down and stays set while all digits seen are zero.
  always_comb begin
    hex_d    = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (value_q[4*k +: 4] == 4'h0);
      if (lamp_test) begin
        hex_d[7*k +: 7] = SEG_ALL;
      end else if (lzb_en && (k != 0) && zero_run) begin
        hex_d[7*k +: 7] = SEG_BLANK;
      end else if (blink_mask[k] && blink_phase_q) begin
        hex_d[7*k +: 7] = SEG_BLANK;
      end else begin
        hex_d[7*k +: 7] = glyph[7*k +: 7];
      end
    end
  end

  // Output register; reset shows every digit blank.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hex_q <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex_out     = hex_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_hex_display_driver_n.sv
// Directed bench for hex_display_driver_n with 4 digits and BLINK_DIV = 4.
module tb_hex_display_driver_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic        live;
  logic        lzb_en;
  logic [3:0]  blink_mask;
  logic        lamp_test;
  logic [27:0] hex_out;
  logic        blink_phase;

  int n_checks = 0;
  int n_fails  = 0;

  // Hand-entered glyph values used for expectations.
  logic [6:0] gl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_display_driver_n #(
    .NUM_DIGITS (4),
    .CLK_HZ     (8),
    .BLINK_HZ   (1)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .value_in    (value_in),
    .load        (load),
    .live        (live),
    .lzb_en      (lzb_en),
    .blink_mask  (blink_mask),
    .lamp_test   (lamp_test),
    .hex_out     (hex_out),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] pk(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Advance n rising edges, then settle on the falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; value_in = '0; load = 1'b0; live = 1'b0;
    lzb_en = 1'b0; blink_mask = '0; lamp_test = 1'b0;
    @(negedge clk);

    // Reset state
    step(2);
    chk("reset_hex", hex_out, 28'hFFFFFFF);
    chk("reset_phase", {27'd0, blink_phase}, 28'd0);
    reset = 1'b0;

    // Load and two-cycle latency
    value_in = 16'h12AF; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("load_lat1", hex_out, pk(7'h40, 7'h40, 7'h40, 7'h40));
    step(1);
    chk("load_12AF", hex_out, pk(7'h79, 7'h24, 7'h08, 7'h0E));
    value_in = 16'hFFFF;
    step(2);
    chk("hold_no_load", hex_out, pk(7'h79, 7'h24, 7'h08, 7'h0E));

    // Leading-zero blanking
    lzb_en = 1'b1; value_in = 16'h0050; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    chk("lzb_0050", hex_out, pk(7'h7F, 7'h7F, 7'h12, 7'h40));
    value_in = 16'h0000; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    chk("lzb_0000", hex_out, pk(7'h7F, 7'h7F, 7'h7F, 7'h40));
    lzb_en = 1'b0;
    step(1);
    chk("lzb_off", hex_out, pk(7'h40, 7'h40, 7'h40, 7'h40));

    // Held load recaptures every cycle
    value_in = 16'h0001; load = 1'b1;
    step(1);
    value_in = 16'h0002;
    step(1);
    load = 1'b0;
    chk("held_load_a", hex_out, pk(7'h40, 7'h40, 7'h40, 7'h79));
    step(1);
    chk("held_load_b", hex_out, pk(7'h40, 7'h40, 7'h40, 7'h24));

    // Blink: realign prescaler with a reset, k = edges since release
    reset = 1'b1;
    step(1);
    reset = 1'b0; value_in = 16'h1234; load = 1'b1; blink_mask = 4'b0001;
    step(1);                                   // k=1
    load = 1'b0;
    chk("blink_ph_k1", {27'd0, blink_phase}, 28'd0);
    step(1);                                   // k=2
    chk("blink_on_k2", hex_out, pk(7'h79, 7'h24, 7'h30, 7'h19));
    step(2);                                   // k=4
    chk("blink_ph_k4", {27'd0, blink_phase}, 28'd1);
    chk("blink_on_k4", hex_out, pk(7'h79, 7'h24, 7'h30, 7'h19));
    step(1);                                   // k=5
    chk("blink_off_k5", hex_out, pk(7'h79, 7'h24, 7'h30, 7'h7F));
    step(3);                                   // k=8
    chk("blink_off_k8", hex_out, pk(7'h79, 7'h24, 7'h30, 7'h7F));
    chk("blink_ph_k8", {27'd0, blink_phase}, 28'd0);
    step(1);                                   // k=9
    chk("blink_on_k9", hex_out, pk(7'h79, 7'h24, 7'h30, 7'h19));

    // Priority: lamp test beats blanking and blink
    lamp_test = 1'b1; lzb_en = 1'b1; value_in = 16'h0000; load = 1'b1;
    step(1);                                   // k=10
    load = 1'b0;
    chk("lamp_k10", hex_out, 28'h0000000);
    step(1);                                   // k=11
    chk("lamp_k11", hex_out, 28'h0000000);
    lamp_test = 1'b0;
    step(1);                                   // k=12, phase seen = 0
    chk("lamp_rel_lzb", hex_out, pk(7'h7F, 7'h7F, 7'h7F, 7'h40));
    step(1);                                   // k=13, phase seen = 1
    chk("lamp_rel_blink", hex_out, 28'hFFFFFFF);
    blink_mask = 4'b0000; lzb_en = 1'b0;

    // Live mode: digit 0 follows value_in two cycles late, load ignored
    live = 1'b1; load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      value_in = 16'(i);
      step(1);
      chk($sformatf("live_%0d", i), hex_out,
          pk(7'h40, 7'h40, 7'h40, gl[(i == 0) ? 0 : i - 1]));
    end

    // Reset overrides load and lamp test
    live = 1'b0; load = 1'b1; lamp_test = 1'b1; value_in = 16'hFFFF; reset = 1'b1;
    step(1);
    chk("rst_mid_hex", hex_out, 28'hFFFFFFF);
    chk("rst_mid_phase", {27'd0, blink_phase}, 28'd0);
    reset = 1'b0; load = 1'b0; lamp_test = 1'b0;
    step(1);                                   // k=1
    chk("rst_value_zero", hex_out, pk(7'h40, 7'h40, 7'h40, 7'h40));
    step(2);                                   // k=3
    chk("rst_ph_k3", {27'd0, blink_phase}, 28'd0);
    step(1);                                   // k=4
    chk("rst_ph_k4", {27'd0, blink_phase}, 28'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
